seq_ctrl_scan: RTL and testbench

Parametrised phase-sequencing controller with a built-in full-scan chain. It steps through NUM_PHASES fixed-length phases on request, with hold and wrap-around behaviour. Every state flop can be shifted in and out serially for fault-injection and reliability campaigns. It sits beside the ISCAS-derived controller benchmarks as a configurable sequential test article.

---
 rtl/seq_ctrl_scan.sv | 160 ++++++++++++++++
 tb/tb_seq_ctrl_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl_scan.sv
// Phase-sequencing controller: steps through NUM_PHASES phases of PHASE_LEN cycles each,
// with hold and wrap, and every state flop on one serial scan chain.
module seq_ctrl_scan #(
   parameter int CNT_W      = 4,
   parameter int NUM_PHASES = 4,
   parameter int PHASE_LEN  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  req_a,
   input  logic                  req_b,
   input  logic                  scan_en,
   input  logic                  scan_in,
   output logic                  scan_out,
   output logic                  busy,
   output logic [NUM_PHASES-1:0] phase_oh,
   output logic [CNT_W-1:0]      cnt,
   output logic                  done
);

   localparam int PIDX_W = $clog2(NUM_PHASES);
   localparam int PIDX_N = 1 << PIDX_W;
   localparam int CHAIN_L = 5 + CNT_W + PIDX_W;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PHASE_LEN - 1);
   localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(NUM_PHASES - 1);
   // Bit i set when phase index i is legal; avoids a compare that is constant at power-of-two sizes.
   localparam logic [PIDX_N-1:0] PIDX_OK   = {PIDX_N{1'b1}} >> (PIDX_N - NUM_PHASES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   state_t              r_state;
   logic [PIDX_W-1:0]   r_pidx;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_done_q;
   logic                r_req_a_q;
   logic                r_req_b_q;

   state_t              w_state_nxt;
   logic [PIDX_W-1:0]   w_pidx_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_done_nxt;
   logic                w_req_a_nxt;
   logic                w_req_b_nxt;
   logic                w_adv;
   logic                w_busy;
   logic                w_illegal;
   logic [CHAIN_L-1:0]  w_chain;
   logic [CHAIN_L-1:0]  w_shift;

   // Chain runs LSB (req_a_q, nearest scan_in) to MSB (state[1], driving scan_out).
   assign w_chain   = {r_state, r_pidx, r_cnt, r_done_q, r_req_b_q, r_req_a_q};
   assign w_shift   = {w_chain[CHAIN_L-2:0], scan_in};
   assign w_busy    = (r_state != ST_IDLE);
   assign w_illegal = (r_state == ST_BAD) || (w_busy && !PIDX_OK[r_pidx]);

   always_comb begin
      // NOTE: every signal gets a default first so no path through the block infers a latch.
      w_state_nxt = r_state;
      w_pidx_nxt  = r_pidx;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = r_done_q;
      w_req_a_nxt = r_req_a_q;
      w_req_b_nxt = r_req_b_q;
      w_adv       = 1'b0;

      if (scan_en) begin
         w_state_nxt = state_t'(w_shift[CHAIN_L-1 -: 2]);
         w_pidx_nxt  = w_shift[3+CNT_W +: PIDX_W];
         w_cnt_nxt   = w_shift[3 +: CNT_W];
         w_done_nxt  = w_shift[2];
         w_req_b_nxt = w_shift[1];
         w_req_a_nxt = w_shift[0];
      end else if (clr) begin
         w_state_nxt = ST_IDLE;
         w_pidx_nxt  = '0;
         w_cnt_nxt   = '0;
         w_done_nxt  = 1'b0;
         w_req_a_nxt = 1'b0;
         w_req_b_nxt = 1'b0;
      end else begin
         w_req_a_nxt = req_a;
         w_req_b_nxt = req_b;
         w_done_nxt  = 1'b0;
         if (w_illegal) begin
            w_state_nxt = ST_IDLE;
            w_pidx_nxt  = '0;
            w_cnt_nxt   = '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (r_req_a_q) begin
                     w_state_nxt = ST_RUN;
                     w_pidx_nxt  = '0;
                     w_cnt_nxt   = '0;
                  end
               end
               ST_RUN: begin
                  if (r_cnt != CNT_LAST) w_cnt_nxt   = r_cnt + 1'b1;
                  else if (r_req_b_q)    w_state_nxt = ST_HOLD;
                  else                   w_adv       = 1'b1;
               end
               ST_HOLD: begin
                  if (!r_req_b_q) w_adv = 1'b1;
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_pidx_nxt  = '0;
                  w_cnt_nxt   = '0;
               end
            endcase

            if (w_adv) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_RUN;
               if (r_pidx != PIDX_LAST) begin
                  w_pidx_nxt = r_pidx + 1'b1;
               end else begin
                  w_pidx_nxt = '0;
                  if (!r_req_a_q) begin
                     w_state_nxt = ST_IDLE;
                     w_done_nxt  = 1'b1;
                  end
               end
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pidx    <= '0;
         r_cnt     <= '0;
         r_done_q  <= 1'b0;
         r_req_a_q <= 1'b0;
         r_req_b_q <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pidx    <= w_pidx_nxt;
         r_cnt     <= w_cnt_nxt;
         r_done_q  <= w_done_nxt;
         r_req_a_q <= w_req_a_nxt;
         r_req_b_q <= w_req_b_nxt;
      end
   end

   assign busy     = w_busy;
   assign phase_oh = w_busy ? (NUM_PHASES'(1) << r_pidx) : '0;
   assign cnt      = r_cnt;
   assign done     = r_done_q;
   assign scan_out = r_state[1];

endmodule

// File: tb/tb_seq_ctrl_scan.sv
// Directed bench for seq_ctrl_scan at default parameters; expected outputs are queued per edge
// from a timeline model and compared as the DUT produces them.
module tb_seq_ctrl_scan;

   localparam int PL = 5;
   localparam int NP = 4;
   localparam int L  = 11;

   typedef struct packed {
      logic       busy;
      logic [3:0] oh;
      logic [3:0] cnt;
      logic       done;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n, clr, req_a, req_b, scan_en, scan_in;
   logic       scan_out, busy, done;
   logic [3:0] phase_oh, cnt;

   int   n_chk = 0;
   int   n_err = 0;
   obs_t exp_q[$];
   logic bit_q[$];

   seq_ctrl_scan #(.CNT_W(4), .NUM_PHASES(NP), .PHASE_LEN(PL)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .req_a(req_a), .req_b(req_b),
      .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
      .busy(busy), .phase_oh(phase_oh), .cnt(cnt), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_cmp(input string tag, input int e);
      obs_t x;
      x = exp_q.pop_front();
      check($sformatf("%s e%0d busy", tag, e), 32'(busy), 32'(x.busy));
      check($sformatf("%s e%0d phase_oh", tag, e), 32'(phase_oh), 32'(x.oh));
      check($sformatf("%s e%0d cnt", tag, e), 32'(cnt), 32'(x.cnt));
      check($sformatf("%s e%0d done", tag, e), 32'(done), 32'(x.done));
   endtask

   // Outputs after edge e for a req_a pulse sampled at edge 1, holding h extra cycles in phase 0.
   function automatic obs_t model_seq(input int e, input int h);
      obs_t o;
      int   k;
      o = '0;
      if (e >= 2 && e < 2 + PL) begin
         o.busy = 1'b1; o.oh = 4'b0001; o.cnt = 4'(e - 2);
      end else if (e >= 2 + PL && e < 2 + PL + h) begin
         o.busy = 1'b1; o.oh = 4'b0001; o.cnt = 4'(PL - 1);
      end else if (e >= 2 + PL) begin
         k = e - 2 - h;
         if (k < NP * PL) begin
            o.busy = 1'b1; o.oh = 4'(1 << (k / PL)); o.cnt = 4'(k % PL);
         end else if (k == NP * PL) begin
            o.done = 1'b1;
         end
      end
      return o;
   endfunction

   // Inputs for the cycle before edge e; req_b sampled high at edges 6..5+h, clr sampled at clr_edge.
   task automatic run_seq(input string tag, input int h, input bit stray_b, input int clr_edge,
                          input int e_max);
      for (int e = 1; e <= e_max; e++) begin
         req_a = (e == 1);
         req_b = (h > 0 && e >= 6 && e < 6 + h) || (stray_b && e == 3);
         clr   = (clr_edge > 0 && e == clr_edge);
         if (clr_edge > 0 && e >= clr_edge) exp_q.push_back('0);
         else                               exp_q.push_back(model_seq(e, h));
         tick();
         pop_cmp(tag, e);
      end
      req_a = 1'b0; req_b = 1'b0; clr = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " phase_oh"}, 32'(phase_oh), 32'd0);
      check({tag, " cnt"}, 32'(cnt), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " scan_out"}, 32'(scan_out), 32'd0);
   endtask

   initial begin
      logic [L-1:0] vec;
      obs_t         w;
      logic         b;

      rst_n = 1'b0; clr = 1'b0; req_a = 1'b0; req_b = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
      #3;
      check_all_zero("por");
      #20 rst_n = 1'b1;
      tick();

      // Basic run with a non-terminal req_b pulse that must be ignored.
      run_seq("basic", 0, 1'b1, 0, 24);
      // Hold phase 0 for nine extra cycles.
      run_seq("hold", 9, 1'b0, 0, 33);
      // clr in phase 2 at cnt=3, then clr coinciding with the final terminal count.
      run_seq("clr_mid", 0, 1'b0, 16, 18);
      run_seq("clr_term", 0, 1'b0, 22, 24);

      // Continuous req_a wraps from the last phase back to phase 0.
      for (int e = 1; e <= 30; e++) begin
         req_a = 1'b1;
         w = '0;
         if (e >= 2) begin
            w.busy = 1'b1;
            w.oh   = 4'(1 << (((e - 2) / PL) % NP));
            w.cnt  = 4'((e - 2) % PL);
         end
         exp_q.push_back(w);
         tick();
         pop_cmp("wrap", e);
      end

      // Asynchronous reset mid-run, away from any clock edge.
      #2 rst_n = 1'b0; req_a = 1'b0;
      #1 check_all_zero("async_rst");
      #3 rst_n = 1'b1;
      tick();

      // Scan-load state=11, pidx=1, cnt=7, done_q=1, req_b_q=0, req_a_q=1 with clr held high.
      vec = {2'b11, 2'b01, 4'b0111, 1'b1, 1'b0, 1'b1};
      scan_en = 1'b1; clr = 1'b1;
      for (int i = L - 1; i >= 0; i--) begin
         scan_in = vec[i];
         tick();
      end
      check("scan_load busy", 32'(busy), 32'd1);
      check("scan_load phase_oh", 32'(phase_oh), 32'b0010);
      check("scan_load cnt", 32'(cnt), 32'd7);
      check("scan_load done", 32'(done), 32'd1);
      check("scan_load scan_out", 32'(scan_out), 32'd1);
      scan_en = 1'b0; clr = 1'b0; scan_in = 1'b0;
      tick();
      check("illegal busy", 32'(busy), 32'd0);
      check("illegal phase_oh", 32'(phase_oh), 32'd0);
      check("illegal cnt", 32'(cnt), 32'd0);
      check("illegal done", 32'(done), 32'd0);
      tick();
      check("illegal idle busy", 32'(busy), 32'd0);
      check("illegal idle done", 32'(done), 32'd0);

      // Pass-through: each bit shifted in appears on scan_out once the chain is full.
      scan_en = 1'b1;
      for (int i = 0; i < 2 * L; i++) begin
         b = 1'($urandom_range(0, 1));
         scan_in = b;
         bit_q.push_back(b);
         tick();
         if (bit_q.size() == L) check($sformatf("scan_thru %0d", i), 32'(scan_out), 32'(bit_q.pop_front()));
      end
      scan_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("final_rst");
      #3 rst_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
